apb_req_arbiter: RTL

- Shares the single APB master bridge between two independent requesters, for example a CPU-side port and a DMA/test port.
- Accepts one request per requester, then runs it as a single APB transfer:
  - drives the bridge's transfer, READ_WRITE, address and write-data inputs;
  - monitors the bridge's PSEL/PENABLE/PREADY/PSLVERR/PRDATA.
- Returns read data and error status to the winning requester with a one-cycle ack.
- Round-robin arbitration, one outstanding transaction at a time.

---
 rtl/apb_req_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin sharing of one APB master bridge between two requesters.
// Optional ISSUE-state timeout is compiled in with `define APB_ARB_TIMEOUT_EN.
module apb_req_arbiter #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic              busy,
    output logic              m_transfer,
    output logic              m_read_write,
    output logic [ADDR_W-1:0] m_write_paddr,
    output logic [ADDR_W-1:0] m_read_paddr,
    output logic [DATA_W-1:0] m_write_data,
    input  logic              m_psel,
    input  logic              m_penable,
    input  logic              m_pready,
    input  logic              m_pslverr,
    input  logic [DATA_W-1:0] m_prdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            state, state_d;
    logic              win, last, rw_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              grant, enable_done, setup_abort, cpl, time_up;

    // last holds the id granted most recently; resetting it to 1 favours req0
    assign grant       = req1 & (~req0 | ~last);
    assign enable_done = m_penable & m_pready;
    assign setup_abort = m_psel & ~m_penable & m_pslverr;
    assign cpl         = enable_done | setup_abort;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn)
            cnt <= '0;
        else
            cnt <= (state == ISSUE) ? cnt + CW'(1) : '0;

    assign time_up = (state == ISSUE) && (cnt == CW'(TIMEOUT - 1));
`else
    assign time_up = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn)
            state <= IDLE;
        else
            state <= state_d;

    always_comb begin
        state_d    = state;
        m_transfer = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        unique case (state)
            IDLE:    state_d = (req0 | req1) ? ISSUE : IDLE;
            ISSUE: begin
                m_transfer = 1'b1;
                state_d    = (cpl | time_up) ? DONE : ISSUE;
            end
            DONE: begin
                ack0    = ~win;
                ack1    = win;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            win     <= 1'b0;
            last    <= 1'b1;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == IDLE && (req0 | req1)) begin
                win     <= grant;
                rw_q    <= grant ? rw1 : rw0;
                addr_q  <= grant ? addr1 : addr0;
                wdata_q <= grant ? wdata1 : wdata0;
            end
            // a SETUP abort or timeout reports an error with no data
            if (state == ISSUE && (cpl | time_up)) begin
                err_q   <= enable_done ? m_pslverr : 1'b1;
                rdata_q <= (enable_done & rw_q) ? m_prdata : '0;
            end
            if (state == DONE)
                last <= win;
        end

    assign busy          = state != IDLE;
    assign m_read_write  = rw_q;
    assign m_write_paddr = addr_q;
    assign m_read_paddr  = addr_q;
    assign m_write_data  = wdata_q;
    assign rdata0        = ack0 ? rdata_q : '0;
    assign rdata1        = ack1 ? rdata_q : '0;
    assign err0          = ack0 & err_q;
    assign err1          = ack1 & err_q;
endmodule
